// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one shared
// one-bit adder cell (two half_adder instances plus a carry flop). Operands
// are processed LSB first, one bit per clock. The result is registered and
// announced with a single-cycle done pulse.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the `sub` input.
// When it is set on an accepted start, B is latched inverted and the carry
// flop is preset, so the cell computes A-B modulo 2^WIDTH.

module half_adder (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, psum_q, sum_q;
  logic [WIDTH-1:0] a_d, b_d, psum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, done_q, cout_q;

  // Values loaded when a start is accepted (B and carry depend on sub mode).
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  // Shared one-bit full-adder cell built from two half adders.
  logic ha0_s, ha0_c, ha1_s, ha1_c;

  half_adder u_ha0 (
    .x_i (a_q[0]),
    .y_i (b_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  half_adder u_ha1 (
    .x_i (ha0_s),
    .y_i (carry_q),
    .s_o (ha1_s),
    .c_o (ha1_c)
  );

  // Next-state values for one RUN step: shift operands, insert sum bit at MSB.
  always_comb begin
    a_d     = a_q >> 1;
    b_d     = b_q >> 1;
    carry_d = ha0_c | ha1_c;
    cnt_d   = cnt_q + CNT_ONE;
    psum_d  = psum_q;
    psum_d[WIDTH-1] = ha1_s;
    for (int i = 0; i < WIDTH - 1; i++) begin
      psum_d[i] = psum_q[i+1];
    end
  end

  // Control FSM and all datapath registers, including the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= CNT_ZERO;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= carry_init;
            cnt_q   <= CNT_ZERO;
            psum_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          psum_q  <= psum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            sum_q   <= psum_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        DONE: begin
          // start is ignored here; the following IDLE cycle may accept it.
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] sum;
  logic       carry_out;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub_s;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub_s),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // One full operation from an idle controller; checks timing and result.
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic [7:0] exp_sum, input logic exp_c,
                        input string name);
    int lat;
    int busy_cnt;
    lat = 0;
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_after_accept: got %b expected 1", name, busy);
    end
    busy_cnt = 1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    n_vec++;
    if (lat !== 8) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected 8", name, lat);
    end
    n_vec++;
    if (busy_cnt !== 8) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d expected 8", name, busy_cnt);
    end
    n_vec++;
    if (sum !== exp_sum) begin
      n_err++;
      $display("FAIL %s sum: got %h expected %h", name, sum, exp_sum);
    end
    n_vec++;
    if (carry_out !== exp_c) begin
      n_err++;
      $display("FAIL %s carry_out: got %b expected %b", name, carry_out, exp_c);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_pulse_width: got %b expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
`ifdef SERIAL_ADDER_SUB_EN
    sub_s = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++;
    if (sum !== 8'h00) begin n_err++; $display("FAIL reset_sum: got %h expected 00", sum); end
    n_vec++;
    if (carry_out !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op(8'h00, 8'h00, 8'h00, 1'b0, "zero");
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, "wrap");
  endtask

  // Operands change right after acceptance; prior result must hold until done.
  task automatic test_inflight();
    int   lat;
    logic hold_ok;
    lat = 0;
    hold_ok = 1'b1;
    a = 8'hA5;
    b = 8'h5A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (sum !== 8'h00 || carry_out !== 1'b1) hold_ok = 1'b0;
    end
    n_vec++;
    if (hold_ok !== 1'b1) begin n_err++; $display("FAIL inflight_hold: got %b expected 1", hold_ok); end
    n_vec++;
    if (lat !== 8) begin n_err++; $display("FAIL inflight_latency: got %0d expected 8", lat); end
    n_vec++;
    if (sum !== 8'hFF) begin n_err++; $display("FAIL inflight_sum: got %h expected ff", sum); end
    n_vec++;
    if (carry_out !== 1'b0) begin n_err++; $display("FAIL inflight_carry: got %b expected 0", carry_out); end
    @(posedge clk); #1;
  endtask

  // start held high: two operations, done pulses 10 cycles apart.
  task automatic test_back_to_back();
    int d1;
    int d2;
    d1 = -1;
    d2 = -1;
    a = 8'h01;
    b = 8'h02;
    start = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (d1 >= 0 && t == d1 + 1) begin
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_ignores_start: busy %b expected 0", busy); end
      end
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1 = t;
          n_vec++;
          if (sum !== 8'h03 || carry_out !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: got %h/%b expected 03/0", sum, carry_out);
          end
          a = 8'h80;
          b = 8'h80;
        end else begin
          d2 = t;
          n_vec++;
          if (sum !== 8'h00 || carry_out !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: got %h/%b expected 00/1", sum, carry_out);
          end
          break;
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (d1 !== 8) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 8", d1); end
    n_vec++;
    if (d2 - d1 !== 10) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 10", d2 - d1); end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_clear: got %b expected 0", done); end
  endtask

  // Reset in the middle of RUN abandons the operation.
  task automatic test_reset_midrun();
    logic saw_done;
    saw_done = 1'b0;
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset_outputs: got busy=%b done=%b sum=%h c=%b expected 0/0/00/0",
               busy, done, sum, carry_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done !== 1'b0) begin n_err++; $display("FAIL midrun_no_done: got %b expected 0", saw_done); end
    run_op(8'h0F, 8'h01, 8'h10, 1'b0, "after_reset");
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    sub_s = 1'b1;
    run_op(8'h10, 8'h01, 8'h0F, 1'b1, "sub_noborrow");
    run_op(8'h01, 8'h02, 8'hFF, 1'b0, "sub_borrow");
    sub_s = 1'b0;
    run_op(8'h01, 8'h02, 8'h03, 1'b0, "sub_off_add");
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_inflight();
    test_back_to_back();
    test_reset_midrun();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial multi-bit adder controller that sequences a single one-bit adder cell (two `half_adder` instances plus a carry flip-flop) over a `WIDTH`-bit operand pair, one bit per clock, LSB first. It accepts a start request and latches the operands. It runs the shared adder cell for exactly `WIDTH` cycles, then presents the registered sum and carry with a one-cycle `done` pulse. It sits between a requester (testbench or higher-level datapath) and the half-adder datapath. It trades `WIDTH`× latency for a single adder cell.

## Interface
- `WIDTH`, 8: operand/result width in bits; legal range 1..32.

- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  WIDTH: operand A; sampled with accepted `start`.
- `b`  in  WIDTH: operand B; sampled with accepted `start`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse; result valid from this cycle.
- `sum`  out  WIDTH: registered result; holds until the next completion.
- `carry_out`  out  1: registered final carry; holds like `sum`.

## Operation
- Reset (async, any time): state to IDLE. Outputs: `busy`=0, `done`=0, `sum`=0, `carry_out`=0. Operand shift registers, partial-sum register, bit counter and carry flop all cleared.
- States: IDLE, RUN, DONE. Encoding is free; no illegal-state lockup. Unreachable encodings go to IDLE on the next edge.
- IDLE:
  - `start`=1 at an edge: latch `a` and `b` into shift registers, clear carry flop and counter, go to RUN.
  - `start`=0: stay in IDLE.
- RUN:
  - Each edge, the adder cell computes s = a0^b0^c and c' = a0&b0 | c&(a0^b0), using the LSBs of the shift registers and the carry flop.
  - s shifts into the partial-sum register from the MSB side, and both operand registers shift right.
  - c' loads the carry flop and the counter increments.
  - On the edge that processes bit WIDTH-1: copy the partial sum (including this bit) to `sum`, copy c' to `carry_out`, go to DONE.
- DONE: `done`=1 for this cycle only; next edge goes to IDLE unconditionally.
- `start` is ignored in RUN and DONE. Requests there are not queued; the requester must hold or reissue `start`.
- `a`/`b` changes after acceptance do not affect the operation in flight.
- Arithmetic: unsigned, modulo 2^WIDTH in `sum`; `carry_out` is bit WIDTH of the true sum.

## Timing
- Let E0 be the edge where `start` is accepted.
- `busy` rises after E0 and falls after E_WIDTH. It is high for exactly WIDTH cycles.
- `sum`/`carry_out` update at E_WIDTH. `done` is high between E_WIDTH and E_WIDTH+1.
- Latency from the accepting edge to `done` is WIDTH cycles.
- Throughput with `start` held high: one operation every WIDTH+2 cycles, because the DONE cycle is followed by an IDLE cycle that accepts the next start.
- WIDTH=1: one RUN cycle; `done` is high between E1 and E2.
- `rst` asserted mid-RUN: operation is abandoned and the result is discarded; no `done` pulse. Outputs are 0 immediately (asynchronously).
- `rst` deasserts: the first possible accept is the first edge with `rst` low.

## Configuration
- `SERIAL_ADDER_SUB_EN`: defined adds input port `sub` (in, 1), sampled with accepted `start`.
  - `sub`=1: B is latched inverted and the carry flop is preset to 1, computing A-B modulo 2^WIDTH. `carry_out`=1 means no borrow (A≥B).
  - `sub`=0: behaviour identical to the add-only build.
- Not defined: no `sub` port; add-only; carry flop always cleared on accept.

## Test plan
- Reset, then WIDTH=8, a=0x00, b=0x00, start pulse → `busy` high for 8 cycles, then `done` pulse with `sum`=0x00, `carry_out`=0.
- a=0xFF, b=0x01 → `sum`=0x00, `carry_out`=1; `done` exactly 8 cycles after the accepting edge.
- a=0xA5, b=0x5A; change `a`/`b` to 0x00 one cycle after accept → `sum`=0xFF, `carry_out`=0. Prior result holds until the `done` cycle.
- `start` held high continuously, alternating operand pairs (0x01+0x02, 0x80+0x80) → results 0x03/0, then 0x00/1. `done` pulses are spaced 10 cycles apart, and a second `start` in RUN is ignored.
- `rst` asserted at RUN cycle 4 of 0xFF+0xFF → all outputs 0 immediately, no `done`. A following 0x0F+0x01 yields `sum`=0x10, `carry_out`=0.
- `SERIAL_ADDER_SUB_EN` defined:
  - 0x10 minus 0x01 gives `sum`=0x0F, `carry_out`=1.
  - 0x01 minus 0x02 gives `sum`=0xFF, `carry_out`=0.
